// File: rtl/mips_pkg.sv
// Shared state/select encodings and reset defaults for the multi-cycle MIPS sequencer.
// The TRAP state and trap next-PC select only exist when MIPS_MC_EXC_EN is defined.
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB
`ifdef MIPS_MC_EXC_EN
      , ST_TRAP
`endif
   } state_e;

   typedef enum logic [1:0] {
      NPC_PLUS4,
      NPC_BRANCH,
      NPC_JUMP
`ifdef MIPS_MC_EXC_EN
      , NPC_TRAP
`endif
   } npc_sel_e;

endpackage

// File: rtl/mips_npc.sv
// Next-PC selection: sequential, conditional branch, J-type jump and (with MIPS_MC_EXC_EN) trap vector.
module mips_npc
   import mips_pkg::*;
#(
   parameter int                ADDR_W  = 32,
   parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(EXC_VEC_DEF)
) (
   input  logic [ADDR_W-1:0] pc,
   input  npc_sel_e          sel,
   input  logic              alu_zero,
   input  logic [31:0]       br_offset,
   input  logic [25:0]       jump_index,
   output logic [ADDR_W-1:0] npc
);

   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] br_disp;

`ifndef MIPS_MC_EXC_EN
   logic [ADDR_W-1:0] unused_exc_vec;
   assign unused_exc_vec = EXC_VEC;
`endif

   // All sums are ADDR_W wide, so wrap-around past the top of the address space is silent.
   always_comb begin
      pc_plus4 = pc + ADDR_W'(4);
      br_disp  = ADDR_W'($signed(br_offset)) << 2;
      npc      = pc_plus4;
      case (sel)
         NPC_BRANCH: if (alu_zero) npc = pc_plus4 + br_disp;
         NPC_JUMP:   npc = {pc_plus4[ADDR_W-1:28], jump_index, 2'b00};
`ifdef MIPS_MC_EXC_EN
         NPC_TRAP:   npc = EXC_VEC;
`endif
         default:    npc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/mips_mc_seq.sv
// Multi-cycle MIPS control sequencer (FETCH/DECODE/EXEC/MEM/WB) around an external decoder, ALU and memory.
// Define MIPS_MC_EXC_EN to add the one-cycle TRAP state and the epc register.
module mips_mc_seq
   import mips_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
   parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(EXC_VEC_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       ir,
   output logic [ADDR_W-1:0] pc,
   input  logic              dec_reg_write,
   input  logic              dec_mem_read,
   input  logic              dec_mem_write,
   input  logic              dec_mem2reg,
   input  logic              dec_branch,
   input  logic              dec_jump,
   input  logic              dec_exception,
   input  logic [31:0]       br_offset,
   input  logic [25:0]       jump_index,
   input  logic [31:0]       alu_out,
   input  logic              alu_zero,
   input  logic [31:0]       rt_val,
   output logic              rf_we,
   output logic [31:0]       rf_wdata,
   output logic              retire
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, npc;
   logic [31:0]       ir_q, ir_d, mdr_q, mdr_d, alu_q, alu_d;
   logic              store_q, store_d;
   logic              pc_load, mem_op;
   npc_sel_e          npc_sel;

`ifdef MIPS_MC_EXC_EN
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic              exc_take;
   assign exc_take = dec_exception | (mem_op & (alu_out[1:0] != 2'b00));
`else
   logic              unused_exc;
   assign unused_exc = dec_exception;
`endif

   assign mem_op    = dec_mem_read | dec_mem_write;
   assign mem_wdata = rt_val;
   assign ir        = ir_q;
   assign pc        = pc_q;
   assign pc_d      = pc_load ? npc : pc_q;

   mips_npc #(
      .ADDR_W     (ADDR_W),
      .EXC_VEC    (EXC_VEC)
   ) u_npc (
      .pc         (pc_q),
      .sel        (npc_sel),
      .alu_zero   (alu_zero),
      .br_offset  (br_offset),
      .jump_index (jump_index),
      .npc        (npc)
   );

   // Next-state and strobes. alu_q doubles as the data address and the write-back ALU result.
   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      mdr_d    = mdr_q;
      alu_d    = alu_q;
      store_d  = store_q;
      pc_load  = 1'b0;
      npc_sel  = NPC_PLUS4;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = pc_q;
      rf_we    = 1'b0;
      rf_wdata = dec_mem2reg ? mdr_q : alu_q;
      retire   = 1'b0;
`ifdef MIPS_MC_EXC_EN
      epc_d    = epc_q;
`endif
      case (state_q)
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_d    = mem_rdata;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC: begin
            alu_d   = alu_out;
            store_d = dec_mem_write;
`ifdef MIPS_MC_EXC_EN
            if (exc_take) begin
               state_d = ST_TRAP;
            end else
`endif
            if (dec_branch || dec_jump) begin
               npc_sel = dec_branch ? NPC_BRANCH : NPC_JUMP;
               pc_load = 1'b1;
               retire  = 1'b1;
               state_d = ST_FETCH;
            end else if (mem_op) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            mem_req  = 1'b1;
            mem_we   = store_q;
            mem_addr = ADDR_W'({alu_q[31:2], 2'b00});
            if (mem_ack) begin
               if (store_q) begin
                  pc_load = 1'b1;
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  mdr_d   = mem_rdata;
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            rf_we   = dec_reg_write;
            pc_load = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
         end
`ifdef MIPS_MC_EXC_EN
         ST_TRAP: begin
            epc_d   = pc_q;
            npc_sel = NPC_TRAP;
            pc_load = 1'b1;
            state_d = ST_FETCH;
         end
`endif
         default: state_d = ST_FETCH;
      endcase
      // While rst is held nothing may be requested, written or retired, even though state is FETCH.
      if (rst) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
         rf_we   = 1'b0;
         retire  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         mdr_q   <= '0;
         alu_q   <= '0;
         store_q <= 1'b0;
`ifdef MIPS_MC_EXC_EN
         epc_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         mdr_q   <= mdr_d;
         alu_q   <= alu_d;
         store_q <= store_d;
`ifdef MIPS_MC_EXC_EN
         epc_q   <= epc_d;
`endif
      end
   end

endmodule

// File: tb/tb_mips_mc_seq.sv
// Bench for mips_mc_seq: plays decoder, ALU and a variable-wait memory; a small model predicts each
// instruction's retire cycle, next PC and write-back, queued per instruction and popped on completion.
module tb_mips_mc_seq;

   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              mem_req, mem_we, mem_ack;
   logic [ADDR_W-1:0] mem_addr, pc;
   logic [31:0]       mem_wdata, mem_rdata, ir;
   logic              dec_reg_write, dec_mem_read, dec_mem_write, dec_mem2reg;
   logic              dec_branch, dec_jump, dec_exception;
   logic [31:0]       br_offset, alu_out, rt_val, rf_wdata;
   logic [25:0]       jump_index;
   logic              alu_zero, rf_we, retire;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] model_pc;

   typedef struct {
      logic [31:0] iword;
      bit          reg_write, mem_read, mem_write, mem2reg, branch, jump, exc, zero, spurious;
      logic [31:0] br_off, alu, rt, rdata;
      logic [25:0] jidx;
      int          fetch_dly, mem_dly;
   } instr_t;

   typedef struct {
      bit          retires, mem_op, we;
      int          latency, rf_cnt;
      logic [31:0] pc_after, rf_data, iword, fetch_addr, mem_addr, wdata;
   } exp_t;

   exp_t sb_q[$];

   mips_mc_seq #(.ADDR_W(ADDR_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .ir            (ir),
      .pc            (pc),
      .dec_reg_write (dec_reg_write),
      .dec_mem_read  (dec_mem_read),
      .dec_mem_write (dec_mem_write),
      .dec_mem2reg   (dec_mem2reg),
      .dec_branch    (dec_branch),
      .dec_jump      (dec_jump),
      .dec_exception (dec_exception),
      .br_offset     (br_offset),
      .jump_index    (jump_index),
      .alu_out       (alu_out),
      .alu_zero      (alu_zero),
      .rt_val        (rt_val),
      .rf_we         (rf_we),
      .rf_wdata      (rf_wdata),
      .retire        (retire)
   );

   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic instr_t blank(input logic [31:0] iword);
      instr_t t;
      t       = '{default: 0};
      t.iword = iword;
      return t;
   endfunction

   task automatic drive_dec(input instr_t in);
      dec_reg_write = in.reg_write;
      dec_mem_read  = in.mem_read;
      dec_mem_write = in.mem_write;
      dec_mem2reg   = in.mem2reg;
      dec_branch    = in.branch;
      dec_jump      = in.jump;
      dec_exception = in.exc;
      br_offset     = in.br_off;
      jump_index    = in.jidx;
      alu_out       = in.alu;
      alu_zero      = in.zero;
      rt_val        = in.rt;
   endtask

   // Reference behaviour of one instruction fetched at pc, zero-wait latencies plus memory waits.
   function automatic exp_t predict(input instr_t in, input logic [31:0] cur_pc);
      exp_t        e;
      logic [31:0] p4;
      p4           = cur_pc + 32'd4;
      e            = '{default: 0};
      e.retires    = 1'b1;
      e.iword      = in.iword;
      e.fetch_addr = cur_pc;
      e.pc_after   = p4;
      e.latency    = in.fetch_dly + 4;
`ifdef MIPS_MC_EXC_EN
      if (in.exc || ((in.mem_read || in.mem_write) && in.alu[1:0] != 2'b00)) begin
         e.retires  = 1'b0;
         e.pc_after = 32'h0000_4180;
         return e;
      end
`endif
      if (in.branch) begin
         e.latency = in.fetch_dly + 3;
         if (in.zero) e.pc_after = p4 + (in.br_off << 2);
      end else if (in.jump) begin
         e.latency  = in.fetch_dly + 3;
         e.pc_after = {p4[31:28], in.jidx, 2'b00};
      end else if (in.mem_write) begin
         e.mem_op   = 1'b1;
         e.we       = 1'b1;
         e.wdata    = in.rt;
         e.mem_addr = {in.alu[31:2], 2'b00};
         e.latency  = in.fetch_dly + 4 + in.mem_dly;
      end else if (in.mem_read) begin
         e.mem_op   = 1'b1;
         e.mem_addr = {in.alu[31:2], 2'b00};
         e.latency  = in.fetch_dly + 5 + in.mem_dly;
         e.rf_cnt   = in.reg_write ? 1 : 0;
         e.rf_data  = in.mem2reg ? in.rdata : in.alu;
      end else begin
         e.rf_cnt   = in.reg_write ? 1 : 0;
         e.rf_data  = in.alu;
      end
      return e;
   endfunction

   // Runs one instruction from FETCH, acting as memory, then pops the prediction and compares.
   task automatic apply_stimulus(input string tag, input instr_t in);
      exp_t        e;
      int          ret_c, rf_cnt, req_len, phase, dly;
      logic [31:0] rf_data, ir_seen, f_addr, m_addr, m_wdata;
      logic        m_we;
      bit          unstable;
      drive_dec(in);
      e = predict(in, model_pc);
      sb_q.push_back(e);
      ret_c = 0; rf_cnt = 0; req_len = 0; phase = 0; unstable = 1'b0;
      rf_data = 'x; ir_seen = 'x; f_addr = 'x; m_addr = 'x; m_wdata = 'x; m_we = 1'bx;
      #1;
      for (int c = 1; c <= 40; c++) begin
         if (mem_req === 1'b1) begin
            if (req_len == 0) begin
               phase++;
               if (phase == 1) f_addr = mem_addr;
               else begin
                  m_addr  = mem_addr;
                  m_we    = mem_we;
                  m_wdata = mem_wdata;
               end
            end else if (phase >= 2 && (mem_addr !== m_addr || mem_we !== m_we)) begin
               unstable = 1'b1;
            end
            dly       = (phase == 1) ? in.fetch_dly : in.mem_dly;
            mem_ack   = (req_len == dly);
            mem_rdata = (phase == 1) ? in.iword : in.rdata;
            req_len   = mem_ack ? 0 : req_len + 1;
         end else begin
            req_len   = 0;
            mem_ack   = in.spurious;
            mem_rdata = 32'hBAD0_BAD0;
         end
         #1;
         if (retire === 1'b1) begin
            ret_c   = c;
            ir_seen = ir;
         end
         if (rf_we === 1'b1) begin
            rf_cnt++;
            rf_data = rf_wdata;
         end
         tick();
         if (ret_c != 0) break;
         if (!e.retires && c == e.latency) break;
      end
      mem_ack = 1'b0;
      e = sb_q.pop_front();
      check_output({tag, "_fetch_addr"}, f_addr, e.fetch_addr);
      check_output({tag, "_pc"}, pc, e.pc_after);
      if (e.retires) begin
         check_output({tag, "_retire_cycle"}, ret_c, e.latency);
         check_output({tag, "_ir"}, ir_seen, e.iword);
         check_output({tag, "_rf_we_cycles"}, rf_cnt, e.rf_cnt);
         if (e.rf_cnt != 0) check_output({tag, "_rf_wdata"}, rf_data, e.rf_data);
      end else begin
         check_output({tag, "_no_retire"}, ret_c, 0);
`ifdef MIPS_MC_EXC_EN
         check_output({tag, "_epc"}, dut.epc_q, e.fetch_addr);
`endif
      end
      if (e.mem_op) begin
         check_output({tag, "_mem_addr"}, m_addr, e.mem_addr);
         check_output({tag, "_mem_we"}, m_we, e.we);
         check_output({tag, "_mem_stable"}, unstable, 0);
         if (e.we) check_output({tag, "_mem_wdata"}, m_wdata, e.wdata);
      end
      model_pc = e.pc_after;
   endtask

   initial begin
      instr_t      in;
      logic [31:0] off;
      rst       = 1'b1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      drive_dec(blank(32'h0));
      tick();
      tick();
      check_output("rst_mem_req", mem_req, 1'b0);
      check_output("rst_pc", pc, 32'h0000_3000);
      check_output("rst_ir", ir, 32'h0);
      check_output("rst_retire", retire, 1'b0);
      check_output("rst_rf_we", rf_we, 1'b0);
      rst      = 1'b0;
      model_pc = 32'h0000_3000;

      in = blank(32'h0109_5020); in.reg_write = 1; in.alu = 32'h0000_1234;
      apply_stimulus("add", in);
      in = blank(32'h0109_5022); in.alu = 32'h5555_0000; in.fetch_dly = 2;
      apply_stimulus("sub_nowrite", in);
      in = blank(32'h1109_FFFF); in.branch = 1; in.zero = 1; in.br_off = 32'hFFFF_FFFF;
      apply_stimulus("beq_taken", in);
      in.zero = 0;
      apply_stimulus("beq_not_taken", in);
      in = blank(32'hAD09_0100); in.mem_write = 1; in.alu = 32'h0000_0100; in.rt = 32'hDEAD_BEEF;
      in.mem_dly = 1;
      apply_stimulus("sw", in);
      in = blank(32'h0000_000C); in.exc = 1; in.alu = 32'h0000_0077;
      apply_stimulus("exc", in);
      in = blank(32'h8D0A_0200); in.mem_read = 1; in.mem2reg = 1; in.reg_write = 1;
      in.alu = 32'h0000_0200; in.rdata = 32'hCAFE_F00D; in.mem_dly = 3;
      apply_stimulus("lw_wait3", in);
      in = blank(32'h0800_1234); in.jump = 1; in.jidx = 26'h0AB_CDEF;
      apply_stimulus("j", in);
      off = (32'hFFFF_FFFC - model_pc - 32'd4) >> 2;
      in = blank(32'h1000_0000); in.branch = 1; in.zero = 1; in.br_off = off;
      apply_stimulus("beq_to_top", in);
      in = blank(32'h0800_0010); in.jump = 1; in.jidx = 26'h000_0010;
      apply_stimulus("j_wrap", in);
      check_output("wrap_target", pc, 32'h0000_0040);
      in = blank(32'h0109_5025); in.reg_write = 1; in.alu = 32'h0F0F_0F0F; in.spurious = 1;
      apply_stimulus("or_spurious_ack", in);

      in = blank(32'h0109_5020);
      drive_dec(in);
      mem_ack = 1'b0;
      tick();
      tick();
      check_output("stall_fetch_req", mem_req, 1'b1);
      rst = 1'b1;
      tick();
      check_output("rstf_mem_req", mem_req, 1'b0);
      check_output("rstf_retire", retire, 1'b0);
      check_output("rstf_pc", pc, 32'h0000_3000);
      rst      = 1'b0;
      model_pc = 32'h0000_3000;
      #1;
      check_output("first_fetch_req", mem_req, 1'b1);
      check_output("first_fetch_addr", mem_addr, 32'h0000_3000);
      in.reg_write = 1; in.alu = 32'h0000_0042;
      apply_stimulus("add_after_rst", in);

      in = blank(32'hAD09_0300); in.mem_write = 1; in.alu = 32'h0000_0300; in.rt = 32'h1357_9BDF;
      drive_dec(in);
      mem_rdata = in.iword;
      mem_ack   = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      tick();
      tick();
      check_output("stall_mem_we", mem_we, 1'b1);
      check_output("stall_mem_addr", mem_addr, 32'h0000_0300);
      rst = 1'b1;
      tick();
      check_output("rstm_mem_req", mem_req, 1'b0);
      check_output("rstm_mem_we", mem_we, 1'b0);
      check_output("rstm_retire", retire, 1'b0);
      check_output("rstm_pc", pc, 32'h0000_3000);
      rst = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
